// File: rtl/instr_pkg.sv
// Shared definitions for the instruction word layout and the fetch-unit FSM.
// Instruction format (26 bits, MSB first):
//   [25:22] ra  [21:18] rb  [17:14] rd  [13] reg_write  [12] use_imm
//   [11] mem_we  [10:8] alu_op  [7:0] imm
package instr_pkg;

  localparam int INSTR_W       = 26;

  localparam int RA_HI         = 25;
  localparam int RA_LO         = 22;
  localparam int RA_W          = RA_HI - RA_LO + 1;

  localparam int RB_HI         = 21;
  localparam int RB_LO         = 18;
  localparam int RB_W          = RB_HI - RB_LO + 1;

  localparam int RD_HI         = 17;
  localparam int RD_LO         = 14;
  localparam int RD_W          = RD_HI - RD_LO + 1;

  localparam int REG_WRITE_BIT = 13;
  localparam int USE_IMM_BIT   = 12;
  localparam int MEM_WE_BIT    = 11;

  localparam int ALU_OP_HI     = 10;
  localparam int ALU_OP_LO     = 8;
  localparam int ALU_OP_W      = ALU_OP_HI - ALU_OP_LO + 1;

  localparam int IMM_HI        = 7;
  localparam int IMM_LO        = 0;
  localparam int IMM_W         = IMM_HI - IMM_LO + 1;

  // Fetch FSM encoding; values are visible to software-side tooling, keep fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  // Decoded view of one instruction word.
  typedef struct packed {
    logic [RA_W-1:0]     ra;
    logic [RB_W-1:0]     rb;
    logic [RD_W-1:0]     rd;
    logic                reg_write;
    logic                use_imm;
    logic                mem_we;
    logic [ALU_OP_W-1:0] alu_op;
    logic [IMM_W-1:0]    imm;
  } instr_fields_t;

  // True while the fetch unit owns the pipeline (fetching or waiting to drain).
  function automatic logic state_is_busy(input fetch_state_e st);
    return (st == ST_RUN) || (st == ST_DRAIN);
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction-word field slicer. Pure wiring: no state, no
// qualification by valid, so it can be dropped into any stage that holds a word.
module instr_decoder
  import instr_pkg::*;
(
  input  logic [INSTR_W-1:0]  instr_i,
  output logic [RA_W-1:0]     ra_o,
  output logic [RB_W-1:0]     rb_o,
  output logic [RD_W-1:0]     rd_o,
  output logic                reg_write_o,
  output logic                use_imm_o,
  output logic                mem_we_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic [IMM_W-1:0]    imm_o
);

  instr_fields_t fields;

  // Slice each field at its fixed bit position.
  always_comb begin
    fields           = '0;
    fields.ra        = instr_i[RA_HI:RA_LO];
    fields.rb        = instr_i[RB_HI:RB_LO];
    fields.rd        = instr_i[RD_HI:RD_LO];
    fields.reg_write = instr_i[REG_WRITE_BIT];
    fields.use_imm   = instr_i[USE_IMM_BIT];
    fields.mem_we    = instr_i[MEM_WE_BIT];
    fields.alu_op    = instr_i[ALU_OP_HI:ALU_OP_LO];
    fields.imm       = instr_i[IMM_HI:IMM_LO];
  end

  assign ra_o        = fields.ra;
  assign rb_o        = fields.rb;
  assign rd_o        = fields.rd;
  assign reg_write_o = fields.reg_write;
  assign use_imm_o   = fields.use_imm;
  assign mem_we_o    = fields.mem_we;
  assign alu_op_o    = fields.alu_op;
  assign imm_o       = fields.imm;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads a combinational ROM, holds the
// fetched word in a single pipeline register and offers it to execute over a
// valid/ready handshake. Supports redirects, a programmable end address and a
// saturating count of accepted hand-offs.
module instr_fetch_unit
  import instr_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 26,
  parameter int END_ADDR = 5,
  parameter int CNT_W    = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [3:0]        out_ra,
  output logic [3:0]        out_rb,
  output logic [3:0]        out_rd,
  output logic              out_reg_write,
  output logic              out_use_imm,
  output logic              out_mem_we,
  output logic [2:0]        out_alu_op,
  output logic [7:0]        out_imm,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  instr_count
);

  localparam logic [ADDR_W-1:0] END_PC  = ADDR_W'(END_ADDR);
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic accept;
  logic capture_ok;

  // Handshake completes whenever a held word meets a ready consumer. A
  // redirect blocks capture so the flush and refetch never overlap.
  assign accept     = out_valid_q & out_ready;
  assign capture_ok = (state_q == ST_RUN) & (~out_valid_q | out_ready) & ~redirect;

  // State, PC, pipeline register and counter; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      instr_q     <= '0;
      out_pc_q    <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      out_pc_q    <= out_pc_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state logic for the fetch FSM, PC and pipeline register.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    out_pc_d    = out_pc_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        // PC is already zero out of reset, so start only has to arm fetching.
        out_valid_d = 1'b0;
        if (start) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (redirect) begin
          // Flush the held word; fetch from the target on the next cycle.
          pc_d        = redirect_pc;
          out_valid_d = 1'b0;
        end else if (capture_ok) begin
          instr_d     = rom_data;
          out_pc_d    = pc_q;
          out_valid_d = 1'b1;
          pc_d        = pc_q + PC_ONE;
          if (pc_q == END_PC) begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (redirect) begin
          pc_d        = redirect_pc;
          out_valid_d = 1'b0;
          state_d     = ST_RUN;
        end else if (accept) begin
          // Last word has been taken: nothing left to hand off.
          out_valid_d = 1'b0;
          state_d     = ST_HALT;
        end
      end

      ST_HALT: begin
        out_valid_d = 1'b0;
        if (start) begin
          pc_d    = '0;
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Count accepted hand-offs, including one accepted in the same cycle as a flush.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  instr_decoder u_decoder (
    .instr_i     (instr_q[INSTR_W-1:0]),
    .ra_o        (out_ra),
    .rb_o        (out_rb),
    .rd_o        (out_rd),
    .reg_write_o (out_reg_write),
    .use_imm_o   (out_use_imm),
    .mem_we_o    (out_mem_we),
    .alu_op_o    (out_alu_op),
    .imm_o       (out_imm)
  );

  assign rom_addr    = pc_q;
  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign busy        = state_is_busy(state_q);
  assign done        = (state_q == ST_HALT);
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. Two instances: one with the default
// end address (5) and one with END_ADDR=63 for the wrap / saturation cases.
// A cycle-level behavioural model per instance predicts every output.
module tb_instr_fetch_unit;

  localparam int AW = 6;
  localparam int DW = 26;
  localparam int CW = 7;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_HALT  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [DW-1:0] rom [64];

  // Instance 0 (END_ADDR=5)
  logic          start0, ready0, redir0;
  logic [AW-1:0] rpc0, rom_addr0, out_pc0;
  logic [DW-1:0] rom_data0;
  logic          out_valid0, rw0, ui0, mw0, busy0, done0;
  logic [3:0]    ra0, rb0, rd0;
  logic [2:0]    alu0;
  logic [7:0]    imm0;
  logic [CW-1:0] cnt0;

  // Instance 1 (END_ADDR=63)
  logic          start1, ready1, redir1;
  logic [AW-1:0] rpc1, rom_addr1, out_pc1;
  logic [DW-1:0] rom_data1;
  logic          out_valid1, rw1, ui1, mw1, busy1, done1;
  logic [3:0]    ra1, rb1, rd1;
  logic [2:0]    alu1;
  logic [7:0]    imm1;
  logic [CW-1:0] cnt1;

  assign rom_data0 = rom[rom_addr0];
  assign rom_data1 = rom[rom_addr1];

  instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .END_ADDR(5), .CNT_W(CW)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .rom_addr(rom_addr0), .rom_data(rom_data0),
    .redirect(redir0), .redirect_pc(rpc0), .out_valid(out_valid0), .out_ready(ready0),
    .out_pc(out_pc0), .out_ra(ra0), .out_rb(rb0), .out_rd(rd0), .out_reg_write(rw0),
    .out_use_imm(ui0), .out_mem_we(mw0), .out_alu_op(alu0), .out_imm(imm0),
    .busy(busy0), .done(done0), .instr_count(cnt0)
  );

  instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .END_ADDR(63), .CNT_W(CW)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .redirect(redir1), .redirect_pc(rpc1), .out_valid(out_valid1), .out_ready(ready1),
    .out_pc(out_pc1), .out_ra(ra1), .out_rb(rb1), .out_rd(rd1), .out_reg_write(rw1),
    .out_use_imm(ui1), .out_mem_we(mw1), .out_alu_op(alu1), .out_imm(imm1),
    .busy(busy1), .done(done1), .instr_count(cnt1)
  );

  // Reference model state, one entry per instance.
  int            m_mode [2];
  int            m_pc   [2];
  bit            m_valid[2];
  int            m_opc  [2];
  logic [DW-1:0] m_word [2];
  int            m_cnt  [2];
  int            m_end  [2];

  int    checks = 0;
  int    errors = 0;
  string phase  = "reset";

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k]  = M_IDLE;
      m_pc[k]    = 0;
      m_valid[k] = 1'b0;
      m_opc[k]   = 0;
      m_word[k]  = '0;
      m_cnt[k]   = 0;
    end
  endfunction

  // One clock of the behavioural rules for instance k.
  function automatic void model_step(input int k, input bit st, input bit rdy,
                                     input bit rd, input int rp);
    bit acc;
    acc = m_valid[k] && rdy;
    if (acc && m_cnt[k] < (1 << CW) - 1) m_cnt[k]++;
    if ((m_mode[k] == M_RUN || m_mode[k] == M_DRAIN) && rd) begin
      m_pc[k]    = rp;
      m_valid[k] = 1'b0;
      m_mode[k]  = M_RUN;
    end else if (m_mode[k] == M_IDLE) begin
      if (st) m_mode[k] = M_RUN;
    end else if (m_mode[k] == M_RUN) begin
      if (!m_valid[k] || rdy) begin
        m_word[k]  = rom[m_pc[k]];
        m_opc[k]   = m_pc[k];
        m_valid[k] = 1'b1;
        if (m_pc[k] == m_end[k]) m_mode[k] = M_DRAIN;
        m_pc[k] = (m_pc[k] + 1) % 64;
      end
    end else if (m_mode[k] == M_DRAIN) begin
      if (acc) begin
        m_valid[k] = 1'b0;
        m_mode[k]  = M_HALT;
      end
    end else begin
      if (st) begin
        m_pc[k]   = 0;
        m_mode[k] = M_RUN;
      end
    end
  endfunction

  task automatic check_dut(input int k);
    logic [AW-1:0] a, op;
    logic          v, b, d;
    logic [CW-1:0] c;
    logic [DW-1:0] f;
    string         p;
    if (k == 0) begin
      a = rom_addr0; op = out_pc0; v = out_valid0; b = busy0; d = done0; c = cnt0;
      f = {ra0, rb0, rd0, rw0, ui0, mw0, alu0, imm0}; p = "u0";
    end else begin
      a = rom_addr1; op = out_pc1; v = out_valid1; b = busy1; d = done1; c = cnt1;
      f = {ra1, rb1, rd1, rw1, ui1, mw1, alu1, imm1}; p = "u1";
    end
    chk({p, ".rom_addr"},  32'(a),  32'(m_pc[k]));
    chk({p, ".out_valid"}, 32'(v),  32'(m_valid[k]));
    chk({p, ".out_pc"},    32'(op), 32'(m_opc[k]));
    chk({p, ".fields"},    32'(f),  32'(m_word[k]));
    chk({p, ".busy"},      32'(b),  32'(m_mode[k] == M_RUN || m_mode[k] == M_DRAIN));
    chk({p, ".done"},      32'(d),  32'(m_mode[k] == M_HALT));
    chk({p, ".count"},     32'(c),  32'(m_cnt[k]));
  endtask

  // Advance one clock: model sees the inputs present at the edge, outputs sampled 1 ns later.
  task automatic cycle();
    @(posedge clk);
    model_step(0, start0, ready0, redir0, int'(rpc0));
    model_step(1, start1, ready1, redir1, int'(rpc1));
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  initial begin
    int cnt_before;
    m_end[0] = 5;
    m_end[1] = 63;
    for (int i = 0; i < 64; i++) rom[i] = DW'($urandom);
    rom[0] = 26'h000307C;
    rom[1] = 26'h1234567;
    rom[2] = 26'h0ABCDEF;
    rom[3] = 26'h006A700;
    rom[4] = 26'h3FFFFFF;
    rom[5] = 26'h2AF2000;

    rst = 1'b1;
    start0 = 0; ready0 = 0; redir0 = 0; rpc0 = '0;
    start1 = 0; ready1 = 0; redir1 = 0; rpc1 = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_dut(0);
    check_dut(1);
    rst = 1'b0;

    // 1/2: straight program run with decode checks.
    phase = "prog";
    start0 = 1; cycle(); start0 = 0; ready0 = 1;
    chk("idle_valid", 32'(out_valid0), 32'd0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("seq_pc", 32'(out_pc0), 32'(i));
      if (i == 0) begin
        chk("pc0_rd", 32'(rd0), 32'h0);
        chk("pc0_rw", 32'(rw0), 32'd1);
        chk("pc0_ui", 32'(ui0), 32'd1);
        chk("pc0_imm", 32'(imm0), 32'h7C);
      end
      if (i == 3) begin
        chk("pc3_ra", 32'(ra0), 32'h0);
        chk("pc3_rb", 32'(rb0), 32'h1);
        chk("pc3_rd", 32'(rd0), 32'hA);
        chk("pc3_rw", 32'(rw0), 32'd1);
        chk("pc3_ui", 32'(ui0), 32'd0);
        chk("pc3_mw", 32'(mw0), 32'd0);
        chk("pc3_alu", 32'(alu0), 32'h7);
      end
      if (i == 5) begin
        chk("pc5_ra", 32'(ra0), 32'hA);
        chk("pc5_rb", 32'(rb0), 32'hB);
        chk("pc5_rd", 32'(rd0), 32'hC);
        chk("pc5_alu", 32'(alu0), 32'h0);
        chk("pc5_imm", 32'(imm0), 32'h0);
      end
    end
    cycle();
    chk("halt_done", 32'(done0), 32'd1);
    chk("halt_count", 32'(cnt0), 32'd6);

    // 3: backpressure at PC2.
    phase = "bp";
    start0 = 1; cycle(); start0 = 0;
    repeat (3) cycle();
    chk("held_pc", 32'(out_pc0), 32'd2);
    ready0 = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_pc", 32'(out_pc0), 32'd2);
      chk("stall_addr", 32'(rom_addr0), 32'd3);
      chk("stall_imm", 32'(imm0), 32'(rom[2][7:0]));
    end
    ready0 = 1;
    cycle();
    chk("release_pc", 32'(out_pc0), 32'd3);
    repeat (4) cycle();
    chk("bp_done", 32'(done0), 32'd1);
    chk("bp_count", 32'(cnt0), 32'd12);

    // 4: redirect while PC4 is held, first stalled, then while being accepted.
    phase = "redir";
    start0 = 1; cycle(); start0 = 0;
    repeat (5) cycle();
    chk("held4", 32'(out_pc0), 32'd4);
    ready0 = 0; redir0 = 1; rpc0 = 6'd1;
    cycle();
    chk("flush_valid", 32'(out_valid0), 32'd0);
    chk("flush_count", 32'(cnt0), 32'd16);
    chk("flush_addr", 32'(rom_addr0), 32'd1);
    redir0 = 0; ready0 = 1;
    cycle();
    chk("refetch_pc", 32'(out_pc0), 32'd1);
    repeat (3) cycle();
    chk("held4b", 32'(out_pc0), 32'd4);
    cnt_before = m_cnt[0];
    redir0 = 1; rpc0 = 6'd1;
    cycle();
    chk("flush_acc_count", 32'(cnt0), 32'(cnt_before + 1));
    redir0 = 0;
    repeat (8) cycle();
    chk("redir_done", 32'(done0), 32'd1);

    // 5: asynchronous reset mid-run.
    phase = "areset";
    start0 = 1; cycle(); start0 = 0;
    repeat (4) cycle();
    chk("pre_pc", 32'(out_pc0), 32'd3);
    #3; rst = 1'b1; #1;
    model_reset();
    chk("rst_valid", 32'(out_valid0), 32'd0);
    chk("rst_imm", 32'(imm0), 32'd0);
    check_dut(0);
    check_dut(1);
    #2; rst = 1'b0;
    start0 = 1; cycle(); start0 = 0;
    cycle();
    chk("restart_pc", 32'(out_pc0), 32'd0);
    repeat (6) cycle();

    // 6: END_ADDR=63 wrap and counter saturation.
    phase = "wrap";
    start1 = 1; ready1 = 1; cycle(); start1 = 0;
    redir1 = 1; rpc1 = 6'd62; cycle(); redir1 = 0;
    cycle();
    chk("cap62", 32'(out_pc1), 32'd62);
    cycle();
    chk("cap63", 32'(out_pc1), 32'd63);
    chk("wrap_addr", 32'(rom_addr1), 32'd0);
    chk("drain_busy", 32'(busy1), 32'd1);
    cycle();
    chk("wrap_done", 32'(done1), 32'd1);
    for (int p = 0; p < 2; p++) begin
      start1 = 1; cycle(); start1 = 0;
      chk("restart_addr", 32'(rom_addr1), 32'd0);
      repeat (70) cycle();
    end
    chk("sat_count", 32'(cnt1), 32'd127);

    // Randomized traffic on both instances against the model.
    phase = "rand";
    for (int i = 0; i < 600; i++) begin
      start0 = ($urandom_range(0, 5) == 0);
      ready0 = ($urandom_range(0, 3) != 0);
      redir0 = ($urandom_range(0, 9) == 0);
      rpc0   = AW'($urandom_range(0, 63));
      start1 = ($urandom_range(0, 5) == 0);
      ready1 = ($urandom_range(0, 2) != 0);
      redir1 = ($urandom_range(0, 15) == 0);
      rpc1   = AW'($urandom_range(0, 63));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Reader side of the 64 x 26-bit instruction ROM. It owns the program counter and drives the ROM address. It captures the returned instruction word into a pipeline register and hands the decoded fields to the execute stage over a valid/ready handshake. It also supports a redirect (branch) input, stops after a programmable end address, and counts retired hand-offs.

Parameters:
ADDR_W, 6, ROM address / PC width (64 words)
DATA_W, 26, instruction word width
END_ADDR, 5, last PC fetched before halting
CNT_W, 7, width of instr_count (saturating)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  pulse: leave IDLE/HALT and fetch from PC 0
rom_addr  out  ADDR_W  address to ROM; equals pc
rom_data  in  DATA_W  combinational ROM read data for rom_addr
redirect  in  1  branch request; valid only in RUN/DRAIN
redirect_pc  in  ADDR_W  branch target
out_valid  out  1  decoded instruction available
out_ready  in  1  execute stage accepts this cycle
out_pc  out  ADDR_W  PC of the held instruction
out_ra  out  4  instr[25:22]
out_rb  out  4  instr[21:18]
out_rd  out  4  instr[17:14]
out_reg_write  out  1  instr[13]
out_use_imm  out  1  instr[12]
out_mem_we  out  1  instr[11]
out_alu_op  out  3  instr[10:8]
out_imm  out  8  instr[7:0]
busy  out  1  state is RUN or DRAIN
done  out  1  state is HALT
instr_count  out  CNT_W  accepted hand-offs, saturates at 2^CNT_W-1

Behaviour:
- Reset (async, immediate) clears everything to zero: state=IDLE, pc=0, instr reg=0, out_pc=0, out_valid=0, instr_count=0, busy=0, done=0.
- States: IDLE, RUN, DRAIN, HALT (2-bit encoding).
- rom_addr = pc at all times. The ROM is combinational, so capture uses rom_data in the same cycle.
- Decoded outputs are pure slices of the instr register. They are zero after reset and change only on capture.
- accept = out_valid & out_ready.
- capture_ok = state==RUN & (!out_valid | out_ready) & !redirect.
- IDLE: out_valid=0.
  - start -> RUN. pc is unchanged; it is already 0 from reset.
- RUN: on capture_ok:
  - instr <= rom_data, out_pc <= pc, out_valid <= 1, pc <= pc+1 (6-bit wrap, 63 -> 0).
  - If the captured pc == END_ADDR -> DRAIN and pc holds its incremented value.
  - Throughput is 1 instruction per cycle with out_ready held high. First out_valid appears 1 cycle after start.
- Backpressure: while out_valid & !out_ready, instr, out_pc and pc hold, and there is no capture.
- DRAIN: no captures.
  - accept -> out_valid <= 0, state -> HALT.
- HALT: out_valid=0, done=1.
  - start -> pc <= 0, state -> RUN. instr_count is not cleared.
- redirect (RUN or DRAIN only; ignored in IDLE/HALT):
  - pc <= redirect_pc, state -> RUN, out_valid <= 0 (the held instruction is flushed). No capture that cycle; fetch resumes the next cycle.
  - If accept is also true that cycle, the held instruction counts as accepted (instr_count increments) before the flush.
- start while in RUN/DRAIN: ignored.
- instr_count increments on every accept and saturates. It never wraps.
- END_ADDR reached via redirect is treated the same as sequential arrival: capture at END_ADDR -> DRAIN.

Decomposition:
- Shared package instr_pkg:
  - field bit positions and widths: RA_HI/LO, RB, RD, REG_WRITE_BIT=13, USE_IMM_BIT=12, MEM_WE_BIT=11, ALU_OP_HI/LO=10/8, IMM_HI/LO=7/0
  - INSTR_W=26
  - fetch state encoding constants (IDLE=0, RUN=1, DRAIN=2, HALT=3)
- One sub-module: instr_decoder, a combinational 26-bit word -> field slicer. The CPU's decode stage reuses it.
- The top level holds the FSM, PC, pipeline register and counter.

Test Plan:
1. Reset, then start, out_ready=1 with the 6-word program:
   - cycle 1: out_pc=0, word 26'h000307C -> rd=0, reg_write=1, use_imm=1, imm=8'h7C.
   - out_pc then advances by 1 each cycle through 5.
   - Then DRAIN -> HALT, done=1, instr_count=6.
2. Decode check:
   - PC3 -> ra=0, rb=1, rd=4'hA, reg_write=1, use_imm=0, mem_we=0, alu_op=3'b111.
   - PC5 -> ra=4'hA, rb=4'hB, rd=4'hC, alu_op=0, imm=0.
3. Backpressure: hold out_ready=0 for 3 cycles at PC2 -> out_pc stays 2, rom_addr stays 3, fields stable; release -> PC3 appears the next cycle, with no skip and no duplicate.
4. Redirect to PC1 while PC4 is held and out_ready=0 -> next cycle out_valid=0, count unchanged, rom_addr=1; the following cycle out_pc=1. Repeat with out_ready=1 -> count +1 for the flushed PC4.
5. Assert rst mid-RUN at PC3 (async, between clock edges) -> all outputs zero immediately, state IDLE; start restarts from PC0.
6. END_ADDR=63, redirect to 62 -> captures 62 and 63, pc wraps to 0, DRAIN -> HALT; start in HALT restarts at 0. Counter saturation check: 130 accepts -> instr_count=127.
